spi_reg_target: RTL and testbench

Parametrised SPI target that emulates an MCP23S17-style register-addressed device. It is oversampled on a single fabric clock instead of being clocked by SCLK. It decodes opcode, address and data bytes and serves a register file with sequential auto-increment. A host-side port lets fabric logic read and update the registers. It sits between the PS/PL SPI controller pins and the GPIO emulation logic, and replaces the fixed-response SPI sink.

---
 rtl/spi_reg_target.sv | 178 +++++++++++++++++
 tb/tb_spi_reg_target.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_target.sv
// SPI mode-0 target, oversampled on clk, serving an MCP23S17-style register file with auto-increment.
// Latency: sclk pin edge -> rise/fall pulse SYNC_STAGES+1 clk, fall -> miso SYNC_STAGES+2 clk; no backpressure.
module spi_reg_target #(
  parameter int         NUM_REGS    = 22,
  parameter int         ADDR_W      = 8,
  parameter logic [2:0] DEV_ADDR    = 3'b000,
  parameter logic [3:0] OPCODE_BASE = 4'b0100,
  parameter int         AUTO_INC    = 1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk_i,
  input  logic              csn_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              abort_o
);

  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync, settle;
  logic                   sclk_s, csn_s, mosi_s, sclk_d, rise, fall, armed;
  state_t                 state, state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             sh_in, sh_out, rx_byte;
  logic [ADDR_W-1:0]      addr, addr_nx, rx_addr;
  logic                   rd_flag, byte_done, op_match, spi_we, load_out;
  logic [7:0]             regs [NUM_REGS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a);
    if (AUTO_INC == 0) return a;
    if (int'(a) >= NUM_REGS - 1) return '0;
    return a + ADDR_W'(1);
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      settle    <= '0;
      sclk_d    <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      rise      <= sclk_s & ~sclk_d;
      fall      <= ~sclk_s & sclk_d;
    end
  end

  assign rx_byte   = {sh_in[6:0], mosi_s};
  assign rx_addr   = rx_byte[ADDR_W-1:0];
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign op_match  = (rx_byte[7:4] == OPCODE_BASE) && (rx_byte[3:1] == DEV_ADDR);
  assign miso_oe_o = (state == S_RDATA);
  assign abort_o   = csn_s && (state != S_IDLE) && (bit_cnt != 3'd0);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    spi_we   = 1'b0;
    load_out = 1'b0;
    case (state)
      S_IDLE:   if (armed && !csn_s) state_nx = S_OPCODE;
      S_OPCODE: if (byte_done) state_nx = op_match ? S_ADDR : S_IGNORE;
      S_ADDR: begin
        if (byte_done) begin
          addr_nx = rx_addr;
          if (!in_range(rx_addr)) begin
            state_nx = S_IGNORE;
          end else if (rd_flag) begin
            state_nx = S_RDATA;
            load_out = 1'b1;
          end else begin
            state_nx = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (byte_done) begin
          spi_we  = 1'b1;
          addr_nx = adv(addr);
        end
      end
      S_RDATA: begin
        if (byte_done) begin
          addr_nx  = adv(addr);
          load_out = 1'b1;
        end
      end
      default: ;
    endcase
    // csn release overrides everything, including a byte completing in the same clk
    if (csn_s) begin
      state_nx = S_IDLE;
      spi_we   = 1'b0;
      load_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      bit_cnt <= 3'd0;
      sh_in   <= 8'h00;
      addr    <= '0;
      rd_flag <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      // only join frames that start after the synchroniser has seen a real idle csn
      if (settle[SYNC_STAGES-1] && csn_s) armed <= 1'b1;
      if (state == S_IDLE) begin
        bit_cnt <= 3'd0;
        sh_in   <= 8'h00;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh_in   <= rx_byte;
      end
      if (state == S_OPCODE && byte_done) rd_flag <= rx_byte[0];
      if (csn_s) busy_o <= 1'b0;
      else if (state == S_OPCODE && byte_done && op_match) busy_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_out       <= 8'h00;
      miso_o       <= 1'b0;
      wr_stb_o     <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= 8'h00;
      host_rdata_o <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb_o <= spi_we;
      if (spi_we) begin
        wr_addr_o <= addr;
        wr_data_o <= rx_byte;
      end
      if (load_out) sh_out <= regs[addr_nx];
      else if (miso_oe_o && fall) sh_out <= {sh_out[6:0], 1'b0};
      if (miso_oe_o && fall) miso_o <= sh_out[7];
      else if (state == S_IDLE) miso_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (spi_we && int'(addr) == i) regs[i] <= rx_byte;
        else if (host_we_i && int'(host_addr_i) == i) regs[i] <= host_wdata_i;
      end
      host_rdata_o <= in_range(host_addr_i) ? regs[host_addr_i] : 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: default, byte-mode and DEV_ADDR=1 instances share the SPI and host pins.
module tb_spi_reg_target;
  localparam int HALF = 8;
  localparam int NREG = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, sclk, csn, mosi, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       miso0, oe0, wr_stb0, busy0, abort0;
  logic       miso1, oe1, wr_stb1, busy1, abort1;
  logic       miso2, oe2, wr_stb2, busy2, abort2;
  logic [7:0] wr_addr0, wr_data0, rdata0, wr_addr1, wr_data1, rdata1, wr_addr2, wr_data2, rdata2;

  spi_reg_target dut0 (
    .clk(clk), .rstn(rstn), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
    .miso_o(miso0), .miso_oe_o(oe0), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_rdata_o(rdata0), .wr_stb_o(wr_stb0),
    .wr_addr_o(wr_addr0), .wr_data_o(wr_data0), .busy_o(busy0), .abort_o(abort0));

  spi_reg_target #(.AUTO_INC(0)) dut1 (
    .clk(clk), .rstn(rstn), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
    .miso_o(miso1), .miso_oe_o(oe1), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_rdata_o(rdata1), .wr_stb_o(wr_stb1),
    .wr_addr_o(wr_addr1), .wr_data_o(wr_data1), .busy_o(busy1), .abort_o(abort1));

  spi_reg_target #(.DEV_ADDR(3'b001)) dut2 (
    .clk(clk), .rstn(rstn), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
    .miso_o(miso2), .miso_oe_o(oe2), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_rdata_o(rdata2), .wr_stb_o(wr_stb2),
    .wr_addr_o(wr_addr2), .wr_data_o(wr_data2), .busy_o(busy2), .abort_o(abort2));

  int          n_cmp = 0, n_err = 0;
  logic [7:0]  mregs [NREG];
  logic [7:0]  tx_q[$], rx_q[$], exp_rx_q[$];
  logic [15:0] wr0_q[$], wr1_q[$], exp_wr_q[$];
  int          oe_q[$];
  int          wr2_cnt = 0, abort0_cnt = 0, busy0_cnt = 0, busy2_cnt = 0, oe2_cnt = 0;

  always @(negedge clk) begin
    if (wr_stb0) wr0_q.push_back({wr_addr0, wr_data0});
    if (wr_stb1) wr1_q.push_back({wr_addr1, wr_data1});
    if (wr_stb2) wr2_cnt++;
    if (abort0) abort0_cnt++;
    if (busy0) busy0_cnt++;
    if (busy2) busy2_cnt++;
    if (oe2) oe2_cnt++;
  end

  // Reference for the default instance: decode the whole frame as bytes, wrap modulo NREG.
  task automatic model_frame();
    logic [7:0] op;
    int a;
    exp_wr_q.delete();
    exp_rx_q.delete();
    if (tx_q.size() < 2) return;
    op = tx_q[0];
    if (op[7:1] != 7'b0100_000) return;
    a = int'(tx_q[1]);
    if (a >= NREG) return;
    for (int i = 2; i < tx_q.size(); i++) begin
      if (op[0]) exp_rx_q.push_back(mregs[a]);
      else begin
        mregs[a] = tx_q[i];
        exp_wr_q.push_back({8'(a), tx_q[i]});
      end
      a = (a + 1) % NREG;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit coll,
                          output logic [7:0] rx, output int n_oe);
    rx = 8'h00;
    n_oe = 0;
    for (int k = 0; k < nbits; k++) begin
      mosi = tx[7-k];
      repeat (HALF) @(negedge clk);
      rx[7-k] = miso0;
      n_oe += int'(oe0);
      sclk = 1'b1;
      if (coll && k == 7) begin
        // rise pulse lands 3 clk after the pin edge; the register write happens on the 4th
        repeat (3) @(negedge clk);
        host_we = 1'b1; host_addr = 8'h02; host_wdata = 8'hC3;
        @(negedge clk);
        host_we = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int coll_byte);
    logic [7:0] r;
    int no;
    rx_q.delete();
    oe_q.delete();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < tx_q.size(); i++) begin
      spi_bits(tx_q[i], 8, (i == coll_byte), r, no);
      rx_q.push_back(r);
      oe_q.push_back(no);
    end
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    if (int'(a) < NREG) mregs[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1,
                           output logic [7:0] d2);
    host_addr = a;
    @(negedge clk);
    d0 = rdata0; d1 = rdata1; d2 = rdata2;
  endtask

  task automatic test_reset();
    logic [7:0] d0, d1, d2;
    rstn = 1'b0; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({miso0, oe0, wr_stb0, busy0, abort0} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 00000", {miso0, oe0, wr_stb0, busy0, abort0});
    end
    n_cmp++;
    if ({wr_addr0, wr_data0, rdata0} !== 24'h0) begin
      n_err++; $display("FAIL reset_data got %h want 000000", {wr_addr0, wr_data0, rdata0});
    end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, NREG - 1));
      host_read(a, d0, d1, d2);
      n_cmp++;
      if (d0 !== mregs[a]) begin
        n_err++; $display("FAIL reset_reg addr %0d got %h want %h", a, d0, mregs[a]);
      end
    end
  endtask

  task automatic test_write_single();
    logic [7:0] d0, d1, d2;
    int base, bcnt;
    base = wr0_q.size(); bcnt = busy0_cnt;
    tx_q = {8'h40, 8'h05, 8'hA5};
    model_frame();
    spi_frame(-1);
    n_cmp++;
    if (wr0_q.size() - base !== 1 || wr0_q[base] !== 16'h05A5) begin
      n_err++; $display("FAIL write_single_stb count %0d want 1", wr0_q.size() - base);
    end
    n_cmp++;
    if (busy0_cnt == bcnt || busy0 !== 1'b0) begin
      n_err++; $display("FAIL write_single_busy cycles %0d now %b want >0 then 0", busy0_cnt - bcnt, busy0);
    end
    host_read(8'h05, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[5]) begin
      n_err++; $display("FAIL write_single_read got %h want %h", d0, mregs[5]);
    end
  endtask

  task automatic test_read_wrap();
    host_write(8'd20, 8'h11);
    host_write(8'd21, 8'h22);
    host_write(8'd0, 8'h33);
    tx_q = {8'h41, 8'h14, 8'h00, 8'h00, 8'h00};
    model_frame();
    spi_frame(-1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rx_q[2+i] !== exp_rx_q[i]) begin
        n_err++; $display("FAIL read_wrap byte %0d got %h want %h", i, rx_q[2+i], exp_rx_q[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (oe_q[i] !== ((i >= 2) ? 8 : 0)) begin
        n_err++; $display("FAIL read_wrap_oe byte %0d got %0d want %0d", i, oe_q[i], (i >= 2) ? 8 : 0);
      end
    end
    n_cmp++;
    if (oe0 !== 1'b0) begin
      n_err++; $display("FAIL read_wrap_oe_after got %b want 0", oe0);
    end
  endtask

  task automatic test_byte_mode();
    logic [7:0] d0, d1, d2;
    int base;
    base = wr1_q.size();
    tx_q = {8'h40, 8'h03, 8'h01, 8'h02};
    model_frame();
    spi_frame(-1);
    n_cmp++;
    if (wr1_q.size() - base !== 2 || wr1_q[base] !== 16'h0301 || wr1_q[base+1] !== 16'h0302) begin
      n_err++; $display("FAIL byte_mode_stb count %0d want 2 at addr 03", wr1_q.size() - base);
    end
    host_read(8'h03, d0, d1, d2);
    n_cmp++;
    if (d1 !== 8'h02) begin
      n_err++; $display("FAIL byte_mode_read got %h want 02", d1);
    end
    host_read(8'h04, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[4]) begin
      n_err++; $display("FAIL auto_inc_read got %h want %h", d0, mregs[4]);
    end
  endtask

  task automatic test_dev_mismatch();
    logic [7:0] d0, d1, d2;
    int w2, b2, o2, base;
    w2 = wr2_cnt; b2 = busy2_cnt; o2 = oe2_cnt;
    tx_q = {8'h40, 8'h00, 8'hFF};
    model_frame();
    spi_frame(-1);
    n_cmp++;
    if (wr2_cnt != w2 || busy2_cnt != b2 || oe2_cnt != o2) begin
      n_err++; $display("FAIL dev_mismatch stb %0d busy %0d oe %0d want 0 0 0",
                        wr2_cnt - w2, busy2_cnt - b2, oe2_cnt - o2);
    end
    base = wr0_q.size();
    tx_q = {8'h42, 8'h00, 8'hFF};
    model_frame();
    spi_frame(-1);
    n_cmp++;
    if (wr2_cnt - w2 != 1) begin
      n_err++; $display("FAIL dev_match_write got %0d want 1", wr2_cnt - w2);
    end
    n_cmp++;
    if (wr0_q.size() - base != exp_wr_q.size()) begin
      n_err++; $display("FAIL dev_other_ignored got %0d want %0d", wr0_q.size() - base, exp_wr_q.size());
    end
    host_read(8'h00, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[0] || d2 !== 8'hFF) begin
      n_err++; $display("FAIL dev_regs got %h/%h want %h/ff", d0, d2, mregs[0]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d0, d1, d2, r;
    int no, a0, base;
    a0 = abort0_cnt; base = wr0_q.size();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h40, 8, 1'b0, r, no);
    spi_bits(8'h07, 8, 1'b0, r, no);
    spi_bits(8'hF0, 4, 1'b0, r, no);
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    n_cmp++;
    if (abort0_cnt - a0 != 1) begin
      n_err++; $display("FAIL abort_pulse got %0d cycles want 1", abort0_cnt - a0);
    end
    n_cmp++;
    if (wr0_q.size() != base) begin
      n_err++; $display("FAIL abort_no_write got %0d want 0", wr0_q.size() - base);
    end
    host_read(8'h07, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[7]) begin
      n_err++; $display("FAIL abort_reg got %h want %h", d0, mregs[7]);
    end
    tx_q = {8'h40, 8'h07, 8'h5C};
    model_frame();
    spi_frame(-1);
    host_read(8'h07, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[7]) begin
      n_err++; $display("FAIL abort_next_frame got %h want %h", d0, mregs[7]);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d0, d1, d2;
    mregs[2] = 8'hC3;
    tx_q = {8'h40, 8'h02, 8'h5A};
    model_frame();
    spi_frame(2);
    host_read(8'h02, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[2]) begin
      n_err++; $display("FAIL collision got %h want %h", d0, mregs[2]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d0, d1, d2, r;
    int no, base, bcnt;
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h41, 8, 1'b0, r, no);
    spi_bits(8'h00, 8, 1'b0, r, no);
    spi_bits(8'h00, 4, 1'b0, r, no);
    n_cmp++;
    if (oe0 !== 1'b1) begin
      n_err++; $display("FAIL mid_read_oe got %b want 1", oe0);
    end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({oe0, busy0, miso0} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset_outputs got %b want 000", {oe0, busy0, miso0});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    base = wr0_q.size(); bcnt = busy0_cnt;
    spi_bits(8'h00, 4, 1'b0, r, no);
    spi_bits(8'h40, 8, 1'b0, r, no);
    spi_bits(8'h01, 8, 1'b0, r, no);
    spi_bits(8'h77, 8, 1'b0, r, no);
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    n_cmp++;
    if (wr0_q.size() != base || busy0_cnt != bcnt) begin
      n_err++; $display("FAIL no_rejoin writes %0d busy %0d want 0 0", wr0_q.size() - base, busy0_cnt - bcnt);
    end
    for (int i = 0; i < NREG; i++) begin
      host_read(8'(i), d0, d1, d2);
      n_cmp++;
      if (d0 !== mregs[i]) begin
        n_err++; $display("FAIL reset_clear reg %0d got %h want %h", i, d0, mregs[i]);
      end
    end
    tx_q = {8'h40, 8'h01, 8'h77};
    model_frame();
    spi_frame(-1);
    host_read(8'h01, d0, d1, d2);
    n_cmp++;
    if (d0 !== mregs[1]) begin
      n_err++; $display("FAIL post_reset_frame got %h want %h", d0, mregs[1]);
    end
  endtask

  task automatic test_random();
    int base, n;
    logic [7:0] a;
    for (int it = 0; it < 10; it++) begin
      a = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(NREG, 255)) : 8'($urandom_range(0, NREG - 1));
      n = $urandom_range(1, 5);
      tx_q = {8'h40, a};
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      base = wr0_q.size();
      model_frame();
      spi_frame(-1);
      n_cmp++;
      if (wr0_q.size() - base != exp_wr_q.size()) begin
        n_err++; $display("FAIL rand_wr_count it %0d got %0d want %0d", it, wr0_q.size() - base, exp_wr_q.size());
      end
      for (int i = 0; i < exp_wr_q.size(); i++) begin
        n_cmp++;
        if (base + i >= wr0_q.size() || wr0_q[base+i] !== exp_wr_q[i]) begin
          n_err++; $display("FAIL rand_wr it %0d idx %0d got %h want %h", it, i,
                            (base + i < wr0_q.size()) ? wr0_q[base+i] : 16'hxxxx, exp_wr_q[i]);
        end
      end
      a = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(NREG, 255)) : 8'($urandom_range(0, NREG - 1));
      n = $urandom_range(1, 4);
      tx_q = {8'h41, a};
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      model_frame();
      spi_frame(-1);
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (exp_rx_q.size() > 0 && rx_q[2+i] !== exp_rx_q[i]) begin
          n_err++; $display("FAIL rand_rd it %0d idx %0d got %h want %h", it, i, rx_q[2+i], exp_rx_q[i]);
        end
        n_cmp++;
        if (oe_q[2+i] !== ((exp_rx_q.size() > 0) ? 8 : 0)) begin
          n_err++; $display("FAIL rand_oe it %0d idx %0d got %0d want %0d", it, i, oe_q[2+i],
                            (exp_rx_q.size() > 0) ? 8 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_wrap();
    test_byte_mode();
    test_dev_mismatch();
    test_abort();
    test_collision();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
